core_control: RTL and testbench

- Parametrised successor to the core run/halt sequencer.
- Gates PC advance (pc_en) and adds a post-reset delay, stall gating, external debug halt/resume, single-step, trap halt and a halt-cause report.
- Sits beside the fetch stage: consumes the current PC and pipeline status, drives pc_en into the PC register and halt/status to the SoC and debug logic.

---
 rtl/core_control_pkg.sv | 26 ++
 rtl/perf_counter.sv | 18 +
 rtl/core_control.sv | 129 ++++++++++++
 tb/tb_core_control.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/core_control_pkg.sv
// Shared types for the core run/halt sequencer: FSM states and halt-cause codes.
package core_control_pkg;

    typedef enum logic [1:0] {
        S_RST  = 2'd0,
        S_RUN  = 2'd1,
        S_STEP = 2'd2,
        S_HALT = 2'd3
    } state_t;

    typedef enum logic [2:0] {
        HC_NONE     = 3'd0,
        HC_PC_MATCH = 3'd1,
        HC_EXT_REQ  = 3'd2,
        HC_STEP     = 3'd3,
        HC_TRAP     = 3'd4
    } halt_cause_t;

    localparam int RST_CNT_W = 8;

    // Terminal causes can only be left through reset.
    function automatic logic is_terminal(input halt_cause_t c);
        return (c == HC_PC_MATCH) || (c == HC_TRAP);
    endfunction

endpackage

// File: rtl/perf_counter.sv
// 64-bit event counter with enable; holds its value when en is low, wraps to 0.
module perf_counter (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    output logic [63:0] count
);

    logic [63:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)     r_count <= '0;
        else if (en) r_count <= r_count + 64'd1;
    end

    assign count = r_count;

endmodule

// File: rtl/core_control.sv
// Core run/halt sequencer: reset delay, stall gating, debug halt/resume/step, trap halt.
// Optional performance counters are enabled with CORE_CONTROL_PERF_COUNTER_EN.
module core_control
    import core_control_pkg::*;
#(
    parameter int              XLEN       = 32,
    parameter logic [XLEN-1:0] HALT_ADDR  = {XLEN{1'b1}},
    parameter int              RST_CYCLES = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] pc,
    input  logic            stall,
    input  logic            trap,
    input  logic            halt_req,
    input  logic            resume_req,
    input  logic            step_req,
    output logic            pc_en,
    output logic            halt,
    output logic [2:0]      halt_cause,
`ifdef CORE_CONTROL_PERF_COUNTER_EN
    output logic [63:0]     cycle_count,
    output logic [63:0]     retire_count,
`endif
    output logic            step_done
);

    localparam logic [RST_CNT_W-1:0] RST_LAST = RST_CNT_W'(RST_CYCLES - 1);

    state_t                r_state, w_next_state;
    halt_cause_t           r_cause, w_next_cause, w_hit_cause;
    logic [RST_CNT_W-1:0]  r_cnt;
    logic                  r_step_done, w_next_step_done;

    // Trap outranks a PC match; halt_req is handled separately since S_STEP ignores it.
    always_comb begin
        w_hit_cause = HC_NONE;
        if (trap)                 w_hit_cause = HC_TRAP;
        else if (pc == HALT_ADDR) w_hit_cause = HC_PC_MATCH;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_RST;
            r_cause     <= HC_NONE;
            r_step_done <= 1'b0;
            r_cnt       <= '0;
        end else begin
            r_state     <= w_next_state;
            r_cause     <= w_next_cause;
            r_step_done <= w_next_step_done;
            if (r_state == S_RST) r_cnt <= r_cnt + 1'b1;
        end
    end

    always_comb begin
        w_next_state     = r_state;
        w_next_cause     = r_cause;
        w_next_step_done = 1'b0;
        case (r_state)
            S_RST: begin
                if (r_cnt == RST_LAST) w_next_state = S_RUN;
            end
            S_RUN: begin
                if (w_hit_cause != HC_NONE) begin
                    w_next_state = S_HALT;
                    w_next_cause = w_hit_cause;
                end else if (halt_req) begin
                    w_next_state = S_HALT;
                    w_next_cause = HC_EXT_REQ;
                end
            end
            S_STEP: begin
                if (w_hit_cause != HC_NONE) begin
                    w_next_state     = S_HALT;
                    w_next_cause     = w_hit_cause;
                    w_next_step_done = 1'b1;
                end else if (!stall) begin
                    w_next_state     = S_HALT;
                    w_next_cause     = HC_STEP;
                    w_next_step_done = 1'b1;
                end
            end
            S_HALT: begin
                if (!is_terminal(r_cause)) begin
                    if (step_req) begin
                        w_next_state = S_STEP;
                        w_next_cause = HC_NONE;
                    end else if (resume_req) begin
                        w_next_state = S_RUN;
                        w_next_cause = HC_NONE;
                    end
                end
            end
            default: begin
                w_next_state = S_RST;
                w_next_cause = HC_NONE;
            end
        endcase
    end

    always_comb begin
        pc_en = ((r_state == S_RUN) || (r_state == S_STEP)) && !stall;
        halt  = (r_state == S_HALT);
    end

    assign halt_cause = r_cause;
    assign step_done  = r_step_done;

`ifdef CORE_CONTROL_PERF_COUNTER_EN
    logic w_cyc_en;
    assign w_cyc_en = (r_state != S_RST) && !halt;

    perf_counter u_cycle_cnt (
        .clk   (clk),
        .rst   (rst),
        .en    (w_cyc_en),
        .count (cycle_count)
    );

    perf_counter u_retire_cnt (
        .clk   (clk),
        .rst   (rst),
        .en    (pc_en),
        .count (retire_count)
    );
`endif

endmodule

// File: tb/tb_core_control.sv
// Scoreboard bench for core_control: driver pushes expected outputs per cycle, monitor checks.
module tb_core_control;

    localparam int          RSTC = 3;
    localparam logic [31:0] HA   = 32'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pc = '0;
    logic        stall = 1'b0, trap = 1'b0, halt_req = 1'b0, resume_req = 1'b0, step_req = 1'b0;
    logic        pc_en, halt, step_done;
    logic [2:0]  halt_cause;
`ifdef CORE_CONTROL_PERF_COUNTER_EN
    logic [63:0] cycle_count, retire_count;
`endif

    core_control #(.XLEN(32), .HALT_ADDR(HA), .RST_CYCLES(RSTC)) dut (
        .clk        (clk),
        .rst        (rst),
        .pc         (pc),
        .stall      (stall),
        .trap       (trap),
        .halt_req   (halt_req),
        .resume_req (resume_req),
        .step_req   (step_req),
        .pc_en      (pc_en),
        .halt       (halt),
        .halt_cause (halt_cause),
`ifdef CORE_CONTROL_PERF_COUNTER_EN
        .cycle_count  (cycle_count),
        .retire_count (retire_count),
`endif
        .step_done  (step_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit               pc_en;
        bit               halt;
        int               cause;
        bit               sd;
        longint unsigned  cyc;
        longint unsigned  ret;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: cycles left in reset delay, halted/stepping flags, cause, counters.
    int              m_rst_left;
    bit              m_halted, m_stepping, m_sd;
    int              m_cause;
    longint unsigned m_cyc, m_ret;

    task automatic model_reset();
        m_rst_left = RSTC; m_halted = 0; m_stepping = 0; m_sd = 0;
        m_cause = 0; m_cyc = 0; m_ret = 0;
    endtask

    task automatic chk(input string name, input longint unsigned act, input longint unsigned req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    // One clock of stimulus: drive at negedge, push the expected outputs, advance the model.
    task automatic cyc(input bit s, input bit t, input bit hr, input bit rr, input bit sr,
                       input logic [31:0] p, input bit r = 0);
        exp_t e;
        int   hit;
        @(negedge clk);
        rst = r; stall = s; trap = t; halt_req = hr; resume_req = rr; step_req = sr; pc = p;
        #1;
        if (r) model_reset();
        e.pc_en = (!r && m_rst_left == 0 && !m_halted && !s);
        e.halt  = m_halted;
        e.cause = m_cause;
        e.sd    = m_sd;
        e.cyc   = m_cyc;
        e.ret   = m_ret;
        q.push_back(e);
        if (r) return;
        if (m_rst_left == 0 && !m_halted) m_cyc++;
        if (e.pc_en) m_ret++;
        m_sd = 0;
        if (m_rst_left > 0) begin
            m_rst_left--;
        end else if (m_halted) begin
            if (m_cause == 2 || m_cause == 3) begin
                if (sr)      begin m_halted = 0; m_stepping = 1; m_cause = 0; end
                else if (rr) begin m_halted = 0; m_cause = 0; end
            end
        end else begin
            hit = t ? 4 : (p == HA) ? 1 : (!m_stepping && hr) ? 2 : (m_stepping && !s) ? 3 : 0;
            if (hit != 0) begin
                m_halted = 1; m_cause = hit; m_sd = m_stepping; m_stepping = 0;
            end
        end
    endtask

    task automatic idle(input int n, input bit s = 0);
        for (int i = 0; i < n; i++) cyc(s, 0, 0, 0, 0, 32'h0);
    endtask

    task automatic do_reset();
        cyc(0, 0, 0, 0, 0, 32'h0, 1);
        cyc(0, 0, 0, 0, 0, 32'h0, 1);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("pc_en", pc_en, e.pc_en);
                chk("halt", halt, e.halt);
                chk("halt_cause", halt_cause, e.cause);
                chk("step_done", step_done, e.sd);
`ifdef CORE_CONTROL_PERF_COUNTER_EN
                chk("cycle_count", cycle_count, e.cyc);
                chk("retire_count", retire_count, e.ret);
`endif
            end
        end
    end

    initial begin : driver
        bit s, t, hr, rr, sr;
        logic [31:0] p;
        model_reset();
        do_reset();
        // Reset delay then free run, then PC match (terminal).
        idle(6);
        cyc(0, 0, 0, 0, 0, 32'h0000_0040);
        cyc(0, 0, 0, 0, 0, HA);
        cyc(0, 0, 0, 1, 0, 32'h0);
        cyc(0, 0, 0, 0, 1, 32'h0);
        idle(2);
        do_reset();
        // External halt, then a single step stretched by two stall cycles.
        idle(5);
        cyc(0, 0, 1, 0, 0, 32'h100);
        idle(2);
        cyc(1, 0, 0, 0, 1, 32'h104);
        cyc(1, 0, 0, 0, 0, 32'h104);
        cyc(1, 0, 0, 0, 0, 32'h104);
        cyc(0, 0, 0, 0, 0, 32'h104);
        idle(2);
        // Resume, then trap + halt_req + PC match together: trap wins and is terminal.
        cyc(0, 0, 0, 1, 0, 32'h108);
        idle(2);
        cyc(0, 1, 1, 0, 0, HA);
        cyc(0, 0, 0, 1, 0, 32'h0);
        cyc(0, 0, 0, 1, 1, 32'h0);
        idle(2);
        do_reset();
        // resume+step together takes the step; async reset mid-step kills it.
        idle(5);
        cyc(0, 0, 1, 0, 0, 32'h200);
        cyc(0, 0, 0, 1, 1, 32'h200);
        cyc(1, 0, 0, 0, 0, 32'h204);
        cyc(1, 0, 0, 0, 0, 32'h204);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("async_rst_pc_en", pc_en, 0);
        chk("async_rst_halt", halt, 0);
        chk("async_rst_step_done", step_done, 0);
        do_reset();
        // Ten run cycles, four of them stalled, then halt and hold.
        idle(RSTC);
        for (int i = 0; i < 10; i++) cyc((i % 3) == 1 || i == 9, 0, 0, 0, 0, 32'h300 + i);
        cyc(0, 0, 1, 0, 0, 32'h400);
        idle(4);
        // Randomized phase against the model.
        for (int n = 0; n < 2500; n++) begin
            if (m_halted && (m_cause == 1 || m_cause == 4)) begin
                do_reset();
            end else begin
                s  = ($urandom_range(0, 2) == 0);
                t  = ($urandom_range(0, 59) == 0);
                hr = ($urandom_range(0, 7) == 0);
                rr = ($urandom_range(0, 3) == 0);
                sr = ($urandom_range(0, 4) == 0);
                p  = ($urandom_range(0, 39) == 0) ? HA : $urandom();
                cyc(s, t, hr, rr, sr, p);
            end
        end
        idle(2);
        @(negedge clk);
        #3;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
